// File: rtl/piso_sched_pkg.sv
// Shared types and sizing helpers for the PISO serial scheduler.
package piso_sched_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StGap   = 2'd2
  } state_e;

  // Width of a counter that must hold 0..n; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n == 0) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from last_grant+1, wrapping at NREQ.
module rr_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_last_grant,
  output logic [NREQ-1:0]         o_grant,
  output logic [$clog2(NREQ)-1:0] o_grant_idx,
  output logic                    o_any_grant
);

  localparam int unsigned IW = $clog2(NREQ);

  int unsigned w_cand;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_any_grant = 1'b0;
    w_cand      = 0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      w_cand = (32'(i_last_grant) + off) % NREQ;
      if (!o_any_grant && i_req[w_cand[IW-1:0]]) begin
        o_any_grant                 = 1'b1;
        o_grant[w_cand[IW-1:0]]     = 1'b1;
        o_grant_idx                 = w_cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/piso_serial_scheduler.sv
// Round-robin shared parallel-in/serial-out serializer with frame/done/owner sideband.
module piso_serial_scheduler
  import piso_sched_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned NREQ      = 4,
  parameter int unsigned MSB_FIRST = 1,
  parameter int unsigned GAP       = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    dout,
  output logic                    frame,
  output logic [$clog2(NREQ)-1:0] sel,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned BW = cnt_width(WIDTH);
  localparam int unsigned GW = cnt_width(GAP);
  localparam logic [BW-1:0] LastBit = BW'(WIDTH);
  localparam logic [GW-1:0] LastGap = GW'(GAP);

  state_e            r_state, w_state_d;
  logic [WIDTH-1:0]  r_shift, w_shift_d;
  logic [BW-1:0]     r_bit_cnt, w_bit_cnt_d;
  logic [GW-1:0]     r_gap_cnt, w_gap_cnt_d;
  logic              r_dout, w_dout_d;
  logic              r_frame, w_frame_d;
  logic              r_busy, w_busy_d;
  logic              r_done, w_done_d;
  logic [IW-1:0]     r_sel, w_sel_d;
  logic [IW-1:0]     r_last_grant, w_last_grant_d;

  logic [NREQ-1:0]   w_grant;
  logic [IW-1:0]     w_grant_idx;
  logic              w_any_grant;
  logic              w_accept;
  logic [WIDTH-1:0]  w_word;
  logic [WIDTH-1:0]  w_word_msb;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .i_req        (req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_grant_idx  (w_grant_idx),
    .o_any_grant  (w_any_grant)
  );

  assign w_accept  = (r_state == StIdle) && w_any_grant;
  assign req_ready = ((r_state == StIdle) && !reset) ? w_grant : '0;
  assign w_word    = req_data[w_grant_idx*WIDTH +: WIDTH];

  // The shifter always emits its top bit; LSB-first words are mirrored on load.
  if (MSB_FIRST != 0) begin : g_msb_first
    assign w_word_msb = w_word;
  end else begin : g_lsb_first
    always_comb begin
      w_word_msb = '0;
      for (int i = 0; i < WIDTH; i++) begin
        w_word_msb[i] = w_word[WIDTH-1-i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_d = StShift;
      StShift: if (r_bit_cnt == LastBit) w_state_d = (GAP == 0) ? StIdle : StGap;
      StGap:   if (r_gap_cnt == LastGap) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_shift_d      = r_shift;
    w_bit_cnt_d    = r_bit_cnt;
    w_gap_cnt_d    = r_gap_cnt;
    w_dout_d       = 1'b0;
    w_frame_d      = 1'b0;
    w_done_d       = 1'b0;
    w_sel_d        = r_sel;
    w_last_grant_d = r_last_grant;
    w_busy_d       = (w_state_d != StIdle);
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          // First bit goes out on the same edge the word is captured.
          w_dout_d       = w_word_msb[WIDTH-1];
          w_shift_d      = {w_word_msb[WIDTH-2:0], 1'b0};
          w_bit_cnt_d    = BW'(1);
          w_frame_d      = 1'b1;
          w_sel_d        = w_grant_idx;
          w_last_grant_d = w_grant_idx;
        end
      end
      StShift: begin
        if (r_bit_cnt == LastBit) begin
          w_bit_cnt_d = '0;
          w_gap_cnt_d = GW'(1);
          w_done_d    = 1'b1;
        end else begin
          w_dout_d    = r_shift[WIDTH-1];
          w_shift_d   = {r_shift[WIDTH-2:0], 1'b0};
          w_bit_cnt_d = r_bit_cnt + 1'b1;
          w_frame_d   = 1'b1;
        end
      end
      StGap: begin
        w_gap_cnt_d = r_gap_cnt + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_dout       <= 1'b0;
      r_frame      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_sel        <= '0;
      r_last_grant <= IW'(NREQ - 1);
    end else begin
      r_shift      <= w_shift_d;
      r_bit_cnt    <= w_bit_cnt_d;
      r_gap_cnt    <= w_gap_cnt_d;
      r_dout       <= w_dout_d;
      r_frame      <= w_frame_d;
      r_busy       <= w_busy_d;
      r_done       <= w_done_d;
      r_sel        <= w_sel_d;
      r_last_grant <= w_last_grant_d;
    end
  end

  assign dout  = r_dout;
  assign frame = r_frame;
  assign busy  = r_busy;
  assign done  = r_done;
  assign sel   = r_sel;

endmodule
